// File: rtl/atm_txn_builder_if.sv
// ----------------------------------------------------------------------------
// atm_txn_builder_if
// Bus between the transaction builder (master) and the ATM core (slave).
//   core_req      master->slave  transaction valid, held until ack/timeout
//   core_ack      slave->master  request accepted and completed
//   core_balance  slave->master  balance, valid with core_ack
//   core_success  slave->master  success flag, valid with core_ack
//   acc_num       master->slave  account number 1..10
//   pin/new_pin   master->slave  binary value of the decimal PIN entries
//   amount        master->slave  binary value of the decimal amount entry
//   operation     master->slave  3 balance, 4 withdraw, 5 deposit, 6 chg PIN
//   language      master->slave  language latched at account entry
// ----------------------------------------------------------------------------
interface atm_txn_builder_if;
   logic        core_req;
   logic        core_ack;
   logic [31:0] core_balance;
   logic        core_success;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [15:0] new_pin;
   logic [31:0] amount;
   logic [2:0]  operation;
   logic        language;

   modport master (
      output core_req, acc_num, pin, new_pin, amount, operation, language,
      input  core_ack, core_balance, core_success
   );

   modport slave (
      input  core_req, acc_num, pin, new_pin, amount, operation, language,
      output core_ack, core_balance, core_success
   );
endinterface

// File: rtl/atm_txn_builder.sv
// ----------------------------------------------------------------------------
// atm_txn_builder
// Assembles an ATM transaction from a digit-serial keypad stream (account,
// PIN, operation, amount / new PIN), issues it to the core over a req/ack
// handshake and reports the core's reply.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   key_valid_i/key_code_i  keypad strobe and code (0-9 digit, 10 ENTER,
//                        11 CLEAR, 12 CANCEL, 13-15 ignored)
//   op_valid_i/op_sel_i  operation select strobe and code
//   language_in_i        language, latched when the account is accepted
//   core_if              master side of the core bus
//   result_valid_o       one-cycle strobe, result_balance_o/success_o valid
//   error_o              one-cycle strobe: entry rejected or ack timeout
//   phase_o              FSM state, busy_o high in ISSUE and DONE
// ----------------------------------------------------------------------------
module atm_txn_builder #(
   parameter int AMT_DIGITS  = 5,
   parameter int PIN_DIGITS  = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid_i,
   input  logic [3:0]            key_code_i,
   input  logic                  op_valid_i,
   input  logic [2:0]            op_sel_i,
   input  logic                  language_in_i,
   atm_txn_builder_if.master     core_if,
   output logic                  result_valid_o,
   output logic [31:0]           result_balance_o,
   output logic                  result_success_o,
   output logic                  error_o,
   output logic [2:0]            phase_o,
   output logic                  busy_o
);

   localparam int MAXD = (AMT_DIGITS > PIN_DIGITS) ?
                         ((AMT_DIGITS > 2) ? AMT_DIGITS : 2) :
                         ((PIN_DIGITS > 2) ? PIN_DIGITS : 2);
   localparam int CW   = $clog2(MAXD + 1);
   localparam int TW   = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACC    = 3'd1,
      S_PIN    = 3'd2,
      S_OP     = 3'd3,
      S_AMT    = 3'd4,
      S_NEWPIN = 3'd5,
      S_ISSUE  = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t          state_q;
   // account held 7 bits wide so a two-digit entry such as 11 or 99 is
   // range-checked on its true value rather than a wrapped 4-bit one
   logic [6:0]      acc_q;
   logic [15:0]     pin_q, new_pin_q;
   logic [31:0]     amt_q;
   logic [2:0]      op_q;
   logic            lang_q;
   logic [CW-1:0]   dcnt_q;
   logic [TW-1:0]   tmo_q;
   logic            core_req_q;
   logic            result_valid_q, result_success_q, error_q;
   logic [31:0]     result_balance_q;

   logic            k_digit, k_enter, k_clear, k_cancel;
   logic [6:0]      acc_d;
   logic [15:0]     pin_d, new_pin_d;
   logic [31:0]     amt_d;
   logic [CW-1:0]   dlim;

   assign k_digit  = key_valid_i && (key_code_i <= 4'd9);
   assign k_enter  = key_valid_i && (key_code_i == 4'd10);
   assign k_clear  = key_valid_i && (key_code_i == 4'd11);
   assign k_cancel = key_valid_i && (key_code_i == 4'd12);

   // candidate field values if the current key is accepted as a digit
   assign acc_d     = acc_q * 7'd10 + {3'd0, key_code_i};
   assign pin_d     = pin_q * 16'd10 + {12'd0, key_code_i};
   assign new_pin_d = new_pin_q * 16'd10 + {12'd0, key_code_i};
   assign amt_d     = amt_q * 32'd10 + {28'd0, key_code_i};

   always_comb begin
      dlim = CW'(PIN_DIGITS);
      case (state_q)
         S_ACC:   dlim = CW'(2);
         S_AMT:   dlim = CW'(AMT_DIGITS);
         default: dlim = CW'(PIN_DIGITS);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         acc_q            <= '0;
         pin_q            <= '0;
         new_pin_q        <= '0;
         amt_q            <= '0;
         op_q             <= '0;
         lang_q           <= 1'b0;
         dcnt_q           <= '0;
         tmo_q            <= '0;
         core_req_q       <= 1'b0;
         result_valid_q   <= 1'b0;
         result_balance_q <= '0;
         result_success_q <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // the first digit both starts the entry and is accumulated
               if (k_digit) begin
                  acc_q   <= {3'd0, key_code_i};
                  dcnt_q  <= CW'(1);
                  state_q <= S_ACC;
               end
            end

            S_ACC, S_PIN, S_AMT, S_NEWPIN: begin
               if (k_cancel) begin
                  state_q <= S_IDLE;
                  acc_q <= '0; pin_q <= '0; new_pin_q <= '0; amt_q <= '0;
                  op_q <= '0; lang_q <= 1'b0; dcnt_q <= '0;
               end else if (k_clear) begin
                  dcnt_q <= '0;
                  case (state_q)
                     S_ACC:   acc_q     <= '0;
                     S_PIN:   pin_q     <= '0;
                     S_AMT:   amt_q     <= '0;
                     default: new_pin_q <= '0;
                  endcase
               end else if (k_digit) begin
                  if (dcnt_q < dlim) begin
                     dcnt_q <= dcnt_q + CW'(1);
                     case (state_q)
                        S_ACC:   acc_q     <= acc_d;
                        S_PIN:   pin_q     <= pin_d;
                        S_AMT:   amt_q     <= amt_d;
                        default: new_pin_q <= new_pin_d;
                     endcase
                  end
               end else if (k_enter && (dcnt_q != '0)) begin
                  dcnt_q <= '0;
                  case (state_q)
                     S_ACC: begin
                        if ((acc_q >= 7'd1) && (acc_q <= 7'd10)) begin
                           lang_q  <= language_in_i;
                           state_q <= S_PIN;
                        end else begin
                           error_q <= 1'b1;
                           state_q <= S_IDLE;
                           acc_q <= '0; pin_q <= '0; new_pin_q <= '0;
                           amt_q <= '0; op_q <= '0; lang_q <= 1'b0;
                        end
                     end
                     S_PIN: state_q <= S_OP;
                     S_AMT: begin
                        if (amt_q == '0) begin
                           error_q <= 1'b1;
                           state_q <= S_IDLE;
                           acc_q <= '0; pin_q <= '0; new_pin_q <= '0;
                           amt_q <= '0; op_q <= '0; lang_q <= 1'b0;
                        end else begin
                           state_q    <= S_ISSUE;
                           core_req_q <= 1'b1;
                           tmo_q      <= '0;
                        end
                     end
                     default: begin
                        state_q    <= S_ISSUE;
                        core_req_q <= 1'b1;
                        tmo_q      <= '0;
                     end
                  endcase
               end
            end

            S_OP: begin
               // CANCEL beats a simultaneous op_valid; other keys are dead here
               if (k_cancel) begin
                  state_q <= S_IDLE;
                  acc_q <= '0; pin_q <= '0; new_pin_q <= '0; amt_q <= '0;
                  op_q <= '0; lang_q <= 1'b0; dcnt_q <= '0;
               end else if (op_valid_i) begin
                  dcnt_q <= '0;
                  case (op_sel_i)
                     3'd3: begin
                        op_q       <= op_sel_i;
                        state_q    <= S_ISSUE;
                        core_req_q <= 1'b1;
                        tmo_q      <= '0;
                     end
                     3'd4, 3'd5: begin
                        op_q    <= op_sel_i;
                        state_q <= S_AMT;
                     end
                     3'd6: begin
                        op_q    <= op_sel_i;
                        state_q <= S_NEWPIN;
                     end
                     default: begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                        acc_q <= '0; pin_q <= '0; new_pin_q <= '0;
                        amt_q <= '0; op_q <= '0; lang_q <= 1'b0;
                     end
                  endcase
               end
            end

            S_ISSUE: begin
               // an ack on the final allowed cycle still wins over the timeout
               if (core_if.core_ack) begin
                  result_balance_q <= core_if.core_balance;
                  result_success_q <= core_if.core_success;
                  result_valid_q   <= 1'b1;
                  core_req_q       <= 1'b0;
                  state_q          <= S_DONE;
               end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                  result_balance_q <= '0;
                  result_success_q <= 1'b0;
                  result_valid_q   <= 1'b1;
                  error_q          <= 1'b1;
                  core_req_q       <= 1'b0;
                  state_q          <= S_IDLE;
                  acc_q <= '0; pin_q <= '0; new_pin_q <= '0; amt_q <= '0;
                  op_q <= '0; lang_q <= 1'b0; dcnt_q <= '0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end

            default: begin // S_DONE: result strobe is high this cycle
               state_q <= S_IDLE;
               acc_q <= '0; pin_q <= '0; new_pin_q <= '0; amt_q <= '0;
               op_q <= '0; lang_q <= 1'b0; dcnt_q <= '0;
            end
         endcase
      end
   end

   assign core_if.core_req  = core_req_q;
   assign core_if.acc_num   = acc_q[3:0];
   assign core_if.pin       = pin_q;
   assign core_if.new_pin   = new_pin_q;
   assign core_if.amount    = amt_q;
   assign core_if.operation = op_q;
   assign core_if.language  = lang_q;

   assign result_valid_o   = result_valid_q;
   assign result_balance_o = result_balance_q;
   assign result_success_o = result_success_q;
   assign error_o          = error_q;
   assign phase_o          = state_q;
   assign busy_o           = (state_q == S_ISSUE) || (state_q == S_DONE);

endmodule
